usart_recv: RTL and testbench

USART_RECV -- requirements
Module: usart_recv

---
 rtl/usart_recv_pkg.sv | 35 +++
 rtl/usart_recv_if.sv | 31 +++
 rtl/uart_recv.sv | 113 +++++++++++
 rtl/usart_recv.sv | 134 +++++++++++++
 tb/tb_usart_recv.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/usart_recv_pkg.sv
// Shared definitions for the 5-byte USART frame: byte count, field layout and FSM encodings.
// Used by both the receiver and the matching transmitter.
package usart_recv_pkg;

    localparam int unsigned FrameBytes = 5;
    localparam int unsigned AddrW      = 2;
    localparam int unsigned ModW       = 6;
    localparam int unsigned DataW      = 24;

    // Byte slots inside a frame (B1..B5 map to 0..4)
    localparam int unsigned SlotAddr   = 0;
    localparam int unsigned SlotMod    = 1;
    localparam int unsigned SlotDataHi = 2;
    localparam int unsigned SlotDataMd = 3;
    localparam int unsigned SlotDataLo = 4;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StCheck
    } frame_state_e;

    typedef enum logic [1:0] {
        StBitIdle,
        StBitStart,
        StBitData,
        StBitStop
    } bit_state_e;

    // Header bytes carry zero padding above the address and mode fields.
    function automatic logic hdr_ok(input logic [7:0] b1, input logic [7:0] b2);
        return (b1[7:AddrW] == '0) && (b2[7:ModW] == '0);
    endfunction

endpackage

// File: rtl/usart_recv_if.sv
// Serial line in, decoded frame fields and status pulses out.
// master = frame decoder (drives fields), slave = line driver / frame consumer.
interface usart_recv_if;
    import usart_recv_pkg::*;

    logic             uart_rxd;
    logic [AddrW-1:0] Adress;
    logic [ModW-1:0]  Mod_SEL;
    logic [DataW-1:0] D;
    logic             frame_vld;
    logic             frame_err;

    modport master (
        input  uart_rxd,
        output Adress,
        output Mod_SEL,
        output D,
        output frame_vld,
        output frame_err
    );

    modport slave (
        output uart_rxd,
        input  Adress,
        input  Mod_SEL,
        input  D,
        input  frame_vld,
        input  frame_err
    );

endinterface

// File: rtl/uart_recv.sv
// 8N1 byte receiver: 2-flop synchronizer, start-bit glitch rejection, mid-bit sampling.
// Emits a one-cycle byte_done (good stop bit) or byte_ferr (stop bit low).
module uart_recv
    import usart_recv_pkg::*;
#(
    parameter int unsigned BPS_CNT = 434
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       rxd_i,
    output logic [7:0] byte_o,
    output logic       byte_done_o,
    output logic       byte_ferr_o
);

    localparam int unsigned HalfCnt = BPS_CNT / 2;
    localparam int unsigned CntW    = $clog2(BPS_CNT + 1);

    logic rxd_meta_q, rxd_sync_q, rxd_prev_q;

    bit_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd_i;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;
        unique case (state_q)
            StBitIdle: begin
                if (rxd_prev_q && !rxd_sync_q) begin
                    state_d = StBitStart;
                    cnt_d   = '0;
                end
            end
            StBitStart: begin
                if (cnt_q == CntW'(HalfCnt - 1)) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    // Line back high at mid-start: treat as noise, no pulse
                    state_d   = rxd_sync_q ? StBitIdle : StBitData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBitData: begin
                if (cnt_q == CntW'(BPS_CNT - 1)) begin
                    cnt_d   = '0;
                    shift_d = {rxd_sync_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = StBitStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBitStop: begin
                if (cnt_q == CntW'(BPS_CNT - 1)) begin
                    cnt_d   = '0;
                    state_d = StBitIdle;
                    done_d  = rxd_sync_q;
                    ferr_d  = !rxd_sync_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StBitIdle;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q   <= StBitIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
        end
    end

    assign byte_o      = shift_q;
    assign byte_done_o = done_q;
    assign byte_ferr_o = ferr_q;

endmodule

// File: rtl/usart_recv.sv
// Frame decoder: collects 5 bytes from uart_recv, checks header padding, publishes
// address/mode/data with frame_vld, or pulses frame_err on timeout, framing error or bad header.
module usart_recv
    import usart_recv_pkg::*;
#(
    parameter int unsigned BPS_CNT   = 434,
    parameter int unsigned GAP_BYTES = 3
) (
    input logic          sys_clk,
    input logic          sys_rst,
    usart_recv_if.master rx_if
);

    localparam int unsigned GapLimit = GAP_BYTES * 10 * BPS_CNT;
    localparam int unsigned GapW     = $clog2(GapLimit + 1);

    logic [7:0] rx_byte;
    logic       byte_done, byte_ferr;

    uart_recv #(
        .BPS_CNT(BPS_CNT)
    ) u_uart_recv (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .rxd_i      (rx_if.uart_rxd),
        .byte_o     (rx_byte),
        .byte_done_o(byte_done),
        .byte_ferr_o(byte_ferr)
    );

    frame_state_e                state_q, state_d;
    logic [2:0]                  idx_q, idx_d;
    logic [GapW-1:0]             gap_q, gap_d;
    logic [FrameBytes-1:0][7:0]  bytes_q, bytes_d;
    logic [AddrW-1:0]            adr_q, adr_d;
    logic [ModW-1:0]             mod_q, mod_d;
    logic [DataW-1:0]            data_q, data_d;
    logic                        vld_q, vld_d;
    logic                        err_q, err_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        bytes_d = bytes_q;
        adr_d   = adr_q;
        mod_d   = mod_q;
        data_d  = data_q;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        // A framing error wins over everything, including a same-cycle gap timeout
        if (byte_ferr) begin
            err_d   = 1'b1;
            state_d = StIdle;
            idx_d   = '0;
            gap_d   = '0;
            bytes_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (byte_done) begin
                        bytes_d[SlotAddr] = rx_byte;
                        idx_d             = 3'd2;
                        gap_d             = '0;
                        state_d           = StCollect;
                    end
                end
                StCollect: begin
                    if (byte_done) begin
                        bytes_d[idx_q - 3'd1] = rx_byte;
                        gap_d                 = '0;
                        if (idx_q == 3'(FrameBytes)) begin
                            state_d = StCheck;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else if (gap_q == GapW'(GapLimit - 1)) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                        idx_d   = '0;
                        gap_d   = '0;
                        bytes_d = '0;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                StCheck: begin
                    state_d = StIdle;
                    idx_d   = '0;
                    if (hdr_ok(bytes_q[SlotAddr], bytes_q[SlotMod])) begin
                        adr_d  = bytes_q[SlotAddr][AddrW-1:0];
                        mod_d  = bytes_q[SlotMod][ModW-1:0];
                        data_d = {bytes_q[SlotDataHi], bytes_q[SlotDataMd], bytes_q[SlotDataLo]};
                        vld_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            gap_q   <= '0;
            bytes_q <= '0;
            adr_q   <= '0;
            mod_q   <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            bytes_q <= bytes_d;
            adr_q   <= adr_d;
            mod_q   <= mod_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    assign rx_if.Adress    = adr_q;
    assign rx_if.Mod_SEL   = mod_q;
    assign rx_if.D         = data_q;
    assign rx_if.frame_vld = vld_q;
    assign rx_if.frame_err = err_q;

endmodule

// File: tb/tb_usart_recv.sv
// Bench for usart_recv: frame-level model predicts each vld/err pulse (kind, time window,
// fields); a per-cycle compare routine checks pulses and held fields against it.
module tb_usart_recv;

    localparam int Bps    = 16;
    localparam int Gap    = 3;
    localparam int GapLim = Gap * 10 * Bps;

    typedef struct {
        int          kind;   // 1 = frame_vld, 2 = frame_err
        logic [1:0]  a;
        logic [5:0]  m;
        logic [23:0] d;
        longint      lo;
        longint      hi;
    } ev_t;

    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    longint cyc   = 0;
    int     checks  = 0;
    int     errors  = 0;
    int     vld_cnt = 0;
    int     err_cnt = 0;
    ev_t    evq[$];

    logic [1:0]  held_a;
    logic [5:0]  held_m;
    logic [23:0] held_d;

    usart_recv_if rx_if ();

    usart_recv #(
        .BPS_CNT  (Bps),
        .GAP_BYTES(Gap)
    ) dut (
        .sys_clk(clk),
        .sys_rst(rst_n),
        .rx_if  (rx_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Called once per cycle at the falling edge, away from the DUT's active edge.
    task automatic monitor();
        ev_t e;
        int  got;
        if (!rst_n) begin
            held_a = '0;
            held_m = '0;
            held_d = '0;
            checks++;
            if (rx_if.frame_vld !== 1'b0 || rx_if.frame_err !== 1'b0) begin
                errors++;
                $display("FAIL reset_pulse: vld %b err %b want 0 0", rx_if.frame_vld,
                         rx_if.frame_err);
            end
        end else if (rx_if.frame_vld === 1'b1 || rx_if.frame_err === 1'b1) begin
            if (rx_if.frame_vld === 1'b1) vld_cnt++;
            if (rx_if.frame_err === 1'b1) err_cnt++;
            checks++;
            if (rx_if.frame_vld === 1'b1 && rx_if.frame_err === 1'b1) begin
                errors++;
                $display("FAIL both_pulses: vld and err together at cyc %0d", cyc);
            end else if (evq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: vld %b err %b at cyc %0d, none expected",
                         rx_if.frame_vld, rx_if.frame_err, cyc);
            end else begin
                e   = evq.pop_front();
                got = (rx_if.frame_vld === 1'b1) ? 1 : 2;
                if (got != e.kind || cyc < e.lo || cyc > e.hi) begin
                    errors++;
                    $display("FAIL event: got kind %0d at cyc %0d want kind %0d in [%0d,%0d]",
                             got, cyc, e.kind, e.lo, e.hi);
                end
                if (e.kind == 1) begin
                    held_a = e.a;
                    held_m = e.m;
                    held_d = e.d;
                end
            end
        end else if (evq.size() != 0 && cyc > evq[0].hi) begin
            checks++;
            errors++;
            $display("FAIL missing_pulse: kind %0d not seen by cyc %0d", evq[0].kind, evq[0].hi);
            void'(evq.pop_front());
        end
        checks++;
        if ({rx_if.Adress, rx_if.Mod_SEL, rx_if.D} !== {held_a, held_m, held_d}) begin
            errors++;
            $display("FAIL fields: got %h/%h/%h want %h/%h/%h", rx_if.Adress, rx_if.Mod_SEL,
                     rx_if.D, held_a, held_m, held_d);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // One 8N1 byte; optionally registers the frame-level pulse this byte must cause.
    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int kind,
                             input int extra, input logic [1:0] a, input logic [5:0] m,
                             input logic [23:0] d);
        ev_t e;
        tick();
        if (kind != 0) begin
            e.kind = kind;
            e.a    = a;
            e.m    = m;
            e.d    = d;
            e.lo   = cyc + 9 * Bps + extra;
            e.hi   = cyc + 11 * Bps + extra;
            evq.push_back(e);
        end
        rx_if.uart_rxd = 1'b0;
        idle(Bps);
        for (int i = 0; i < 8; i++) begin
            rx_if.uart_rxd = b[i];
            idle(Bps);
        end
        rx_if.uart_rxd = stop_ok;
        idle(Bps);
        rx_if.uart_rxd = 1'b1;
    endtask

    // f = {B1,B2,B3,B4,B5}; bad = index of byte with a low stop bit (-1 for none).
    task automatic send_frame(input logic [39:0] f, input int bad, input int gap);
        int         kind;
        int         last;
        logic [7:0] b;
        last = (bad >= 0) ? bad : 4;
        for (int i = 0; i <= last; i++) begin
            b    = f[39-8*i -: 8];
            kind = 0;
            if (i == last) begin
                kind = (bad >= 0 || f[39:34] != 6'd0 || f[31:30] != 2'd0) ? 2 : 1;
            end
            send_byte(b, (i != bad), kind, 0, f[33:32], f[29:24], f[23:0]);
            if (i != last) idle(gap);
        end
    endtask

    int         v0, e0;
    logic [39:0] rf;
    int          rbad;

    initial begin
        rx_if.uart_rxd = 1'b1;
        rst_n = 1'b0;
        idle(4);
        chk("rst_adr", rx_if.Adress, 0);
        chk("rst_mod", rx_if.Mod_SEL, 0);
        chk("rst_d", rx_if.D, 0);
        chk("rst_vld", rx_if.frame_vld, 0);
        chk("rst_err", rx_if.frame_err, 0);
        rst_n = 1'b1;
        idle(Bps);

        // Back-to-back good frame
        v0 = vld_cnt; e0 = err_cnt;
        send_frame(40'h02_15_AB_CD_EF, -1, 0);
        idle(3 * Bps);
        chk("s1_vld", vld_cnt - v0, 1);
        chk("s1_err", err_cnt - e0, 0);
        chk("s1_adr", rx_if.Adress, 2);
        chk("s1_mod", rx_if.Mod_SEL, 32'h15);
        chk("s1_d", rx_if.D, 32'hABCDEF);

        // Three bytes then silence: gap timeout, then a good frame
        v0 = vld_cnt; e0 = err_cnt;
        send_byte(8'h01, 1'b1, 0, 0, 2'd0, 6'd0, 24'd0);
        send_byte(8'h02, 1'b1, 0, 0, 2'd0, 6'd0, 24'd0);
        send_byte(8'h03, 1'b1, 2, GapLim, 2'd0, 6'd0, 24'd0);
        idle(4 * 10 * Bps);
        chk("s2_err", err_cnt - e0, 1);
        chk("s2_vld", vld_cnt - v0, 0);
        send_frame(40'h01_3F_00_00_01, -1, 0);
        idle(3 * Bps);
        chk("s2_vld2", vld_cnt - v0, 1);
        chk("s2_d", rx_if.D, 32'h000001);

        // Low stop bit on B3 keeps previous outputs
        v0 = vld_cnt; e0 = err_cnt;
        send_frame(40'h03_11_22_44_66, 2, 0);
        idle(10 * Bps);
        chk("s3_err", err_cnt - e0, 1);
        chk("s3_adr", rx_if.Adress, 1);
        chk("s3_mod", rx_if.Mod_SEL, 32'h3F);
        chk("s3_d", rx_if.D, 32'h000001);
        send_frame(40'h00_2A_12_34_56, -1, 0);
        idle(3 * Bps);
        chk("s3_vld", vld_cnt - v0, 1);
        chk("s3_d2", rx_if.D, 32'h123456);

        // Non-zero header padding
        v0 = vld_cnt; e0 = err_cnt;
        send_frame(40'h06_01_02_03_04, -1, 0);
        idle(3 * Bps);
        chk("s4_err", err_cnt - e0, 1);
        chk("s4_vld", vld_cnt - v0, 0);
        chk("s4_d", rx_if.D, 32'h123456);

        // Short low glitch
        v0 = vld_cnt; e0 = err_cnt;
        rx_if.uart_rxd = 1'b0;
        idle(5);
        rx_if.uart_rxd = 1'b1;
        idle(2 * 10 * Bps);
        chk("s5_err", err_cnt - e0, 0);
        chk("s5_vld", vld_cnt - v0, 0);

        // Reset after B2 discards the partial frame
        send_byte(8'h01, 1'b1, 0, 0, 2'd0, 6'd0, 24'd0);
        send_byte(8'h22, 1'b1, 0, 0, 2'd0, 6'd0, 24'd0);
        rst_n = 1'b0;
        idle(3);
        chk("s6_adr", rx_if.Adress, 0);
        chk("s6_mod", rx_if.Mod_SEL, 0);
        chk("s6_d", rx_if.D, 0);
        rst_n = 1'b1;
        idle(Bps);
        v0 = vld_cnt; e0 = err_cnt;
        send_frame(40'h03_01_FF_FF_FF, -1, 0);
        idle(3 * Bps);
        chk("s6_vld", vld_cnt - v0, 1);
        chk("s6_err", err_cnt - e0, 0);
        chk("s6_adr2", rx_if.Adress, 3);
        chk("s6_d2", rx_if.D, 32'hFFFFFF);

        // Randomized frames: occasional bad header or bad stop bit, random inter-byte gaps
        for (int n = 0; n < 12; n++) begin
            rf = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 63)), 24'($urandom)};
            if ($urandom_range(0, 3) == 0) rf[39:32] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rf[31:24] = 8'($urandom);
            rbad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
            send_frame(rf, rbad, int'($urandom_range(0, 12 * Bps)));
            idle(int'($urandom_range(2 * Bps, 6 * Bps)));
        end

        for (int i = 0; i < 20 * Bps && evq.size() != 0; i++) tick();
        chk("queue_empty", evq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
